// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: op codes, FSM state encoding and op-class helpers shared by alu_mdu
// and its iterative multiply/divide datapath.
package alu_mdu_pkg;

    localparam int unsigned OPW = 5;

    typedef enum logic [OPW-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_EQ     = 5'd10,
        OP_NE     = 5'd11,
        OP_LT     = 5'd12,
        OP_GE     = 5'd13,
        OP_LTU    = 5'd14,
        OP_GEU    = 5'd15,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHU  = 5'd18,
        OP_MULHSU = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply/divide class; whether it actually iterates also depends on operands and build.
    function automatic logic is_long_op(input logic [OPW-1:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_mul_op(input logic [OPW-1:0] op);
        return (op >= OP_MUL) && (op <= OP_MULHSU);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: shared radix-2 shift-add multiplier / restoring divider over magnitudes.
// Runs WIDTH steps after start; last_c flags the final step and hi_c/lo_c carry its result.
module alu_mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] ma,
    input  logic [WIDTH-1:0] mb,
    output logic             last_c,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    localparam int unsigned CW = $clog2(WIDTH);

    // hi: product high half / partial remainder; lo: multiplier / quotient; dsr: multiplicand / divisor
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] dsr;
    logic             div_q;
    logic             run;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum_c;
    logic             ge_c;
    logic [WIDTH-1:0] shl_c;

    always_comb begin
        sum_c  = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : '0);
        shl_c  = {hi[WIDTH-2:0], lo[WIDTH-1]};
        ge_c   = {hi, lo[WIDTH-1]} >= {1'b0, dsr};
        last_c = run && (cnt == CW'(WIDTH - 1));
        if (div_q) begin
            hi_c = ge_c ? (shl_c - dsr) : shl_c;
            lo_c = {lo[WIDTH-2:0], ge_c};
        end else begin
            hi_c = sum_c[WIDTH:1];
            lo_c = {sum_c[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            dsr   <= '0;
            div_q <= 1'b0;
            run   <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            hi    <= '0;
            lo    <= ma;
            dsr   <= mb;
            div_q <= is_div;
            run   <= 1'b1;
            cnt   <= '0;
        end else if (run) begin
            hi  <= hi_c;
            lo  <= lo_c;
            cnt <= cnt + CW'(1);
            if (last_c) run <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked execute-stage ALU with registered results, branch compares and RV32M mul/div.
// Define ALU_MDU_FAST_MUL_EN for a single-cycle combinational multiplier; divides stay iterative.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             f,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [OPW-1:0]   op_q;
    logic             neg_q;

    logic             accept_c;
    logic             long_c;
    logic [WIDTH-1:0] short_c;
    logic             short_f_c;
    logic             sa_c, sb_c, neg_c;
    logic [WIDTH-1:0] ma_c, mb_c;
    logic [SHW-1:0]   shamt_c;
    logic             lt_s_c, lt_u_c, div_zero_c, div_ovf_c;

    logic             iter_last_c;
    logic [WIDTH-1:0] iter_hi_c, iter_lo_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0] long_res_c;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept_c = in_valid && in_ready;

    // Signed operands are reduced to magnitudes; neg_c says whether the result needs negating.
    always_comb begin
        sa_c  = 1'b0;
        sb_c  = 1'b0;
        neg_c = 1'b0;
        case (op)
            OP_MULH, OP_DIV: begin
                sa_c  = a[WIDTH-1];
                sb_c  = b[WIDTH-1];
                neg_c = a[WIDTH-1] ^ b[WIDTH-1];
            end
            OP_MULHSU: begin
                sa_c  = a[WIDTH-1];
                neg_c = a[WIDTH-1];
            end
            OP_REM: begin
                sa_c  = a[WIDTH-1];
                sb_c  = b[WIDTH-1];
                neg_c = a[WIDTH-1];
            end
            default: ;
        endcase
        ma_c = sa_c ? -a : a;
        mb_c = sb_c ? -b : b;
    end

`ifdef ALU_MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fmag_c, fprod_c;
    assign fmag_c  = (2*WIDTH)'(ma_c) * (2*WIDTH)'(mb_c);
    assign fprod_c = neg_c ? -fmag_c : fmag_c;
`endif

    // Single-cycle datapath; divide special cases also resolve here without iterating.
    always_comb begin
        shamt_c    = b[SHW-1:0];
        lt_s_c     = $signed(a) < $signed(b);
        lt_u_c     = a < b;
        div_zero_c = (b == '0);
        div_ovf_c  = (a == MIN_NEG) && (b == '1);
        short_c    = a + b;
        short_f_c  = 1'b0;
        long_c     = 1'b0;
        case (op)
            OP_SUB:  short_c = a - b;
            OP_AND:  short_c = a & b;
            OP_OR:   short_c = a | b;
            OP_XOR:  short_c = a ^ b;
            OP_SLL:  short_c = a << shamt_c;
            OP_SRL:  short_c = a >> shamt_c;
            OP_SRA:  short_c = $unsigned($signed(a) >>> shamt_c);
            OP_SLT:  short_c = WIDTH'(lt_s_c);
            OP_SLTU: short_c = WIDTH'(lt_u_c);
            OP_EQ:   begin short_c = '0; short_f_c = (a == b); end
            OP_NE:   begin short_c = '0; short_f_c = (a != b); end
            OP_LT:   begin short_c = '0; short_f_c = lt_s_c;   end
            OP_GE:   begin short_c = '0; short_f_c = !lt_s_c;  end
            OP_LTU:  begin short_c = '0; short_f_c = lt_u_c;   end
            OP_GEU:  begin short_c = '0; short_f_c = !lt_u_c;  end
            OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU: begin
`ifdef ALU_MDU_FAST_MUL_EN
                short_c = (op == OP_MUL) ? fprod_c[WIDTH-1:0] : fprod_c[2*WIDTH-1:WIDTH];
`else
                long_c  = 1'b1;
`endif
            end
            OP_DIV, OP_REM: begin
                if (div_zero_c)     short_c = (op == OP_DIV) ? '1 : a;
                else if (div_ovf_c) short_c = (op == OP_DIV) ? a : '0;
                else                long_c  = 1'b1;
            end
            OP_DIVU, OP_REMU: begin
                if (div_zero_c) short_c = (op == OP_DIVU) ? '1 : a;
                else            long_c  = 1'b1;
            end
            default: ;
        endcase
    end

    alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept_c && long_c),
        .is_div (!is_mul_op(op)),
        .ma     (ma_c),
        .mb     (mb_c),
        .last_c (iter_last_c),
        .hi_c   (iter_hi_c),
        .lo_c   (iter_lo_c)
    );

    // Sign fix-up of the iterative result on its final step.
    always_comb begin
        prod_c = neg_q ? -{iter_hi_c, iter_lo_c} : {iter_hi_c, iter_lo_c};
        case (op_q)
            OP_MUL:                        long_res_c = prod_c[WIDTH-1:0];
            OP_MULH, OP_MULHU, OP_MULHSU:  long_res_c = prod_c[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               long_res_c = neg_q ? -iter_lo_c : iter_lo_c;
            default:                       long_res_c = neg_q ? -iter_hi_c : iter_hi_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            c         <= '0;
            f         <= 1'b0;
            busy      <= 1'b0;
            op_q      <= OP_ADD;
            neg_q     <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    if (iter_last_c) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        c         <= long_res_c;
                        f         <= 1'b0;
                    end
                end
                default: begin
                    if (accept_c) begin
                        op_q  <= op;
                        neg_q <= neg_c;
                        if (long_c) begin
                            state     <= BUSY;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            c         <= short_c;
                            f         <= short_f_c;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for alu_mdu; directed vectors with hand-computed results and latencies.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam int unsigned W = 32;
`ifdef ALU_MDU_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = W + 1;
    localparam int MUL_BUSY = W;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   op = 5'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] c;
    logic         f;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_cyc = -1;

    typedef struct { logic [W-1:0] c; logic f; int cyc; int id; } exp_t;
    exp_t sb[$];

    typedef struct { logic [4:0] op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] c; logic f; int lat; } vec_t;
    vec_t vecs [0:27] = '{
        '{OP_ADD,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1},
        '{OP_SRA,    32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1},
        '{OP_SUB,    32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1},
        '{OP_SLL,    32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 1},
        '{OP_SRL,    32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1},
        '{OP_OR,     32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0, 1'b0, 1},
        '{OP_XOR,    32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1},
        '{OP_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1},
        '{OP_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1},
        '{OP_LT,     32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1},
        '{OP_LTU,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1},
        '{OP_EQ,     32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1},
        '{OP_EQ,     32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0, 1},
        '{OP_NE,     32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1},
        '{OP_GE,     32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1},
        '{OP_GEU,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1},
        '{5'd31,     32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1},
        '{OP_DIV,    32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1},
        '{OP_REM,    32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0, 1},
        '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1},
        '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1},
        '{OP_DIVU,   32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1},
        '{OP_REMU,   32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0, 1},
        '{OP_MUL,    32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 1'b0, MUL_LAT},
        '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MUL_LAT},
        '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MUL_LAT},
        '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, DIV_LAT},
        '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, DIV_LAT}
    };

    alu_mdu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .f         (f),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec%0d got %h expected %h", nm, id, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the accept.
    task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ec, input logic ef, input int lat, input int id,
                         input bit push, output int waited);
        op = o; a = x; b = y; in_valid = 1'b1; waited = 0;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("accept", id, W'(in_ready), W'(1));
        if (push) sb.push_back('{c: ec, f: ef, cyc: cyc + lat, id: id});
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 5'($urandom);
        a = $urandom;
        b = $urandom;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", -1, W'(sb.size()), W'(0));
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (rst_n && out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output got c=%h f=%b expected none", c, f);
                    end else begin
                        e = sb.pop_front();
                        chk("result_c", e.id, c, e.c);
                        chk("result_f", e.id, W'(f), W'(e.f));
                        chk("latency", e.id, W'(first_cyc), W'(e.cyc));
                    end
                    first_cyc = -1;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int nb;
        int i;
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_out_valid", -1, W'(out_valid), W'(0));
        chk("rst_c", -1, c, W'(0));
        chk("rst_f", -1, W'(f), W'(0));
        chk("rst_in_ready", -1, W'(in_ready), W'(1));
        chk("rst_busy", -1, W'(busy), W'(0));
        @(negedge clk);

        for (int k = 0; k < 28; k++)
            issue(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].f, vecs[k].lat, k, 1'b1, w);
        drain();

        // MULH with busy-window count
        issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, MUL_LAT, 100, 1'b1, w);
        nb = 0;
        i = 0;
        #1;
        while (!out_valid && i < 100) begin
            if (busy) nb++;
            @(negedge clk); #1;
            i++;
        end
        chk("mulh_busy_cycles", 100, W'(nb), W'(MUL_BUSY));
        drain();

        // Backpressure: DIVU result held, then a new AND accepted in the releasing cycle
        out_ready = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, DIV_LAT, 101, 1'b1, w);
        i = 0;
        #1;
        while (!out_valid && i < 100) begin
            @(negedge clk); #1;
            i++;
        end
        chk("bp_out_valid", 101, W'(out_valid), W'(1));
        for (int k = 0; k < 5; k++) begin
            chk("bp_c_stable", 101, c, 32'd14);
            chk("bp_in_ready", 101, W'(in_ready), W'(0));
            @(negedge clk); #1;
        end
        out_ready = 1'b1;
        issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1, 102, 1'b1, w);
        chk("bp_same_cycle_accept", 102, W'(w), W'(0));
        drain();

        // Reset during a DIV: no output may appear afterwards
        issue(OP_DIV, 32'd1000, 32'd3, 32'd333, 1'b0, DIV_LAT, 103, 1'b0, w);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("midrst_out_valid", 103, W'(out_valid), W'(0));
        chk("midrst_c", 103, c, W'(0));
        chk("midrst_in_ready", 103, W'(in_ready), W'(1));
        chk("midrst_busy", 103, W'(busy), W'(0));
        repeat (40) @(negedge clk);
        issue(OP_ADD, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1, 104, 1'b1, w);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, handshaked successor to the mySoC single-cycle ALU.
- Registers all results.
- Adds RV32M-style multiply/divide, computed iteratively over multiple cycles, and signed/unsigned branch compares.
- Sits in the execute stage between operand-forward muxes and writeback, and stalls the pipeline via in_ready while a long op is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from b (derived; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  op/a/b valid this cycle
- in_ready  out  1  block accepts an op this cycle
- op  in  5  operation code (alu_mdu_pkg)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  c/f valid
- out_ready  in  1  consumer takes result
- c  out  WIDTH  result
- f  out  1  branch-taken flag; 0 for non-compare ops
- busy  out  1  iterative op in progress

Behaviour:
- Clock and reset: single clock clk; rst_n synchronous, active-low.
- Reset values: state=IDLE, out_valid=0, c=0, f=0, busy=0, in_ready=1 in the cycle after reset release.
- Reset mid-operation: abandons any op, no output produced.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept occurs when in_valid & in_ready.
- Base ops, 1-cycle latency (accept at edge k, out_valid after edge k+1):
  - ADD, SUB, AND, OR, XOR.
  - SLL, SRL, SRA: shift by b[SHW-1:0]; SRA is signed.
  - SLT, SLTU: c = {0..., lt}.
  - Result modulo 2^WIDTH; no overflow flag.
- Compare ops, 1-cycle latency, c=0:
  - EQ, NE, LT, GE (signed), LTU, GEU (unsigned).
  - f = condition.
- MUL, MULH, MULHU, MULHSU:
  - Radix-2 shift-add, one bit per cycle, WIDTH cycles in BUSY.
  - Magnitudes with sign fix-up at the end; out_valid WIDTH+1 cycles after accept.
  - MUL returns the low half of the product; MULH* return the high half.
- DIV, DIVU, REM, REMU:
  - Restoring division over magnitudes, WIDTH cycles in BUSY, same latency as multiply.
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Divide by zero: skips BUSY, latency 1. Quotient = all ones; remainder = a.
- Signed overflow (a = most-negative, b = -1): skips BUSY, latency 1. DIV returns a; REM returns 0.
- DONE:
  - out_valid=1; c/f held stable until out_ready.
  - out_ready with in_valid: the new op is accepted in the same cycle; out_valid drops or re-asserts per the new op's latency.
  - A 1-cycle op accepted from DONE gives back-to-back results.
- Operand changes: a/b/op are ignored outside the accept cycle; operands are latched internally.
- busy=1 exactly while state==BUSY.
- Undefined op code: treated as ADD.

Optional Feature:
- Macro: ALU_MDU_FAST_MUL_EN.
- Defined: multiplies use a single-cycle combinational WIDTHxWIDTH multiplier with latency 1, skipping BUSY. Divides remain iterative.
- Undefined: multiplies are iterative as above. This keeps area minimal for FPGA targets without DSPs.

Decomposition:
- alu_mdu_pkg holds:
  - Op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, EQ=10, NE=11, LT=12, GE=13, LTU=14, GEU=15, MUL=16, MULH=17, MULHU=18, MULHSU=19, DIV=20, DIVU=21, REM=22, REMU=23.
  - State encoding.
  - is_long_op() helper.
- One sub-module, alu_mdu_iter: shared shift-add/restoring-divide datapath with start/done and WIDTH-cycle counter.
- The single-cycle datapath stays inline in alu_mdu.

Test Plan:
- Reset: hold rst_n=0 three cycles during a DIV → after release out_valid=0, c=0, in_ready=1.
- ADD then SRA back-to-back, out_ready=1:
  - ADD 0xFFFFFFFF+1 → c=0 at cycle 1.
  - SRA 0x80000000 by 0x24 → c=0xF8000000 at cycle 2.
- Compares:
  - BLT a=0xFFFFFFFF, b=1 → f=1.
  - BLTU same operands → f=0.
  - BEQ 5,5 → f=1; c=0 in all three cases.
- MULH a=0x80000000, b=0x80000000 → c=0x40000000, out_valid at cycle 33, busy high for cycles 1-32. With ALU_MDU_FAST_MUL_EN: cycle 1.
- Divide specials:
  - DIV 7/0 → c=0xFFFFFFFF at cycle 1.
  - REM 7/0 → c=7.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM -7/2 → c=0xFFFFFFFF at cycle 33.
- Backpressure: hold out_ready=0 for 5 cycles after DIVU 100/7 → c=14 stable, in_ready=0. Then out_ready=1 with a new in_valid AND → accepted in the same cycle.
